// File: rtl/demux_1a2_reg_if.sv
// ----------------------------------------------------------------------------
// demux_1a2_reg_if
//   Handshake bundle for the registered 1-to-2 demultiplexer.
//
//   Input channel : entrada, entrada_valida, sel  (upstream -> block)
//                   entrada_lista                 (block -> upstream)
//   Output ch. 0  : salida_0, salida_0_valida     (block -> consumer 0)
//                   salida_0_lista                (consumer 0 -> block)
//   Output ch. 1  : salida_1, salida_1_valida     (block -> consumer 1)
//                   salida_1_lista                (consumer 1 -> block)
//
//   Modports:
//     master : the side that feeds words in and consumes both outputs
//     slave  : the demultiplexer itself
// ----------------------------------------------------------------------------
interface demux_1a2_reg_if #(
    parameter int ANCHO = 11
) ();

    logic [ANCHO-1:0] entrada;
    logic             entrada_valida;
    logic             sel;
    logic             entrada_lista;

    logic [ANCHO-1:0] salida_0;
    logic             salida_0_valida;
    logic             salida_0_lista;

    logic [ANCHO-1:0] salida_1;
    logic             salida_1_valida;
    logic             salida_1_lista;

    modport master (
        output entrada,
        output entrada_valida,
        output sel,
        input  entrada_lista,
        input  salida_0,
        input  salida_0_valida,
        output salida_0_lista,
        input  salida_1,
        input  salida_1_valida,
        output salida_1_lista
    );

    modport slave (
        input  entrada,
        input  entrada_valida,
        input  sel,
        output entrada_lista,
        output salida_0,
        output salida_0_valida,
        input  salida_0_lista,
        output salida_1,
        output salida_1_valida,
        input  salida_1_lista
    );

endinterface : demux_1a2_reg_if

// File: rtl/demux_1a2_reg.sv
// ----------------------------------------------------------------------------
// demux_1a2_reg
//   Registered 1-to-2 demultiplexer. Each word presented on the input channel
//   is steered by `sel` into one of two 2-entry buffers; each buffer drains
//   through its own valid/ready handshake, so a stalled consumer only stalls
//   the words aimed at it.
//
//   Ports:
//     clk      : single clock, rising edge
//     rst_n    : asynchronous active-low reset (empties and clears buffers)
//     vaciar   : synchronous flush of both buffers (storage left untouched)
//     bus      : demux_1a2_reg_if.slave (input channel + two output channels)
//     cuenta_0 : 16-bit pop counter of channel 0   (DEMUX_1A2_CONTADORES_EN)
//     cuenta_1 : 16-bit pop counter of channel 1   (DEMUX_1A2_CONTADORES_EN)
//
//   Optional feature macro: DEMUX_1A2_CONTADORES_EN
//     Defined   -> per-channel wrapping pop counters and their output ports.
//     Undefined -> no counters, no extra ports; behaviour otherwise identical.
//
//   entrada_lista depends only on registered full flags and `sel`; there is
//   no combinational path from either salida_x_lista to the input side.
// ----------------------------------------------------------------------------
module demux_1a2_reg #(
    parameter int ANCHO = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vaciar,
    demux_1a2_reg_if.slave       bus
`ifdef DEMUX_1A2_CONTADORES_EN
    ,
    output logic [15:0]          cuenta_0,
    output logic [15:0]          cuenta_1
`endif
);

    // Storage: [channel][entry]
    logic [ANCHO-1:0] mem_r [2][2];
    logic [1:0]       count_r [2];
    logic [1:0]       wptr_r;
    logic [1:0]       rptr_r;
    logic [1:0]       full_r;

    logic [1:0]       push_s;
    logic [1:0]       pop_s;
    logic [1:0]       lista_out_s;
    logic [1:0]       count_nxt_s [2];
    logic             entrada_lista_s;

    // Input acceptance: only the full flag of the addressed channel matters
    always_comb begin
        entrada_lista_s = 1'b1;
        if (bus.sel == 1'b1) begin
            entrada_lista_s = ~full_r[1];
        end else begin
            entrada_lista_s = ~full_r[0];
        end
    end

    // Push/pop strobes; sel is qualified by entrada_valida so an idle sel
    // value never reaches the state
    always_comb begin
        lista_out_s[0] = bus.salida_0_lista;
        lista_out_s[1] = bus.salida_1_lista;
        push_s[0] = bus.entrada_valida & entrada_lista_s & ~bus.sel;
        push_s[1] = bus.entrada_valida & entrada_lista_s &  bus.sel;
        for (int c = 0; c < 2; c++) begin
            pop_s[c] = (count_r[c] != 2'd0) & lista_out_s[c];
        end
    end

    // Next occupancy per channel; a push into a full buffer never happens
    // because entrada_lista was low, so the +1 case cannot overflow
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            count_nxt_s[c] = count_r[c];
            case ({push_s[c], pop_s[c]})
                2'b10:   count_nxt_s[c] = count_r[c] + 2'd1;
                2'b01:   count_nxt_s[c] = count_r[c] - 2'd1;
                2'b11:   count_nxt_s[c] = count_r[c];
                2'b00:   count_nxt_s[c] = count_r[c];
                default: count_nxt_s[c] = count_r[c];
            endcase
        end
    end

    // Buffer state: reset clears storage, flush only rewinds pointers/counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                count_r[c] <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    mem_r[c][e] <= {ANCHO{1'b0}};
                end
            end
            wptr_r <= 2'b00;
            rptr_r <= 2'b00;
            full_r <= 2'b00;
        end else if (vaciar) begin
            for (int c = 0; c < 2; c++) begin
                count_r[c] <= 2'd0;
            end
            wptr_r <= 2'b00;
            rptr_r <= 2'b00;
            full_r <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push_s[c]) begin
                    mem_r[c][wptr_r[c]] <= bus.entrada;
                    wptr_r[c]           <= ~wptr_r[c];
                end else begin
                    wptr_r[c]           <= wptr_r[c];
                end
                if (pop_s[c]) begin
                    rptr_r[c] <= ~rptr_r[c];
                end else begin
                    rptr_r[c] <= rptr_r[c];
                end
                count_r[c] <= count_nxt_s[c];
                full_r[c]  <= (count_nxt_s[c] == 2'd2);
            end
        end
    end

`ifdef DEMUX_1A2_CONTADORES_EN
    logic [15:0] cuenta_0_r;
    logic [15:0] cuenta_1_r;

    // Pop counters: survive a flush, and a flush cycle's pop is not a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_0_r <= 16'h0000;
            cuenta_1_r <= 16'h0000;
        end else if (vaciar) begin
            cuenta_0_r <= cuenta_0_r;
            cuenta_1_r <= cuenta_1_r;
        end else begin
            if (pop_s[0]) begin
                cuenta_0_r <= cuenta_0_r + 16'd1;
            end else begin
                cuenta_0_r <= cuenta_0_r;
            end
            if (pop_s[1]) begin
                cuenta_1_r <= cuenta_1_r + 16'd1;
            end else begin
                cuenta_1_r <= cuenta_1_r;
            end
        end
    end

    assign cuenta_0 = cuenta_0_r;
    assign cuenta_1 = cuenta_1_r;
`endif

    // Outputs are selected straight from registered state
    assign bus.entrada_lista   = entrada_lista_s;
    assign bus.salida_0        = mem_r[0][rptr_r[0]];
    assign bus.salida_1        = mem_r[1][rptr_r[1]];
    assign bus.salida_0_valida = (count_r[0] != 2'd0);
    assign bus.salida_1_valida = (count_r[1] != 2'd0);

endmodule : demux_1a2_reg

// File: tb/tb_demux_1a2_reg.sv
// ----------------------------------------------------------------------------
// tb_demux_1a2_reg
//   Directed self-checking bench for demux_1a2_reg. Inputs change 1 time
//   unit after a rising edge; outputs are sampled at that same point (or
//   1 unit later when a combinational input-side response is being checked).
// ----------------------------------------------------------------------------
module tb_demux_1a2_reg;

    localparam int ANCHO = 11;

    logic clk = 1'b0;
    logic rst_n;
    logic vaciar;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    demux_1a2_reg_if #(.ANCHO(ANCHO)) bus ();

`ifdef DEMUX_1A2_CONTADORES_EN
    logic [15:0] cuenta_0;
    logic [15:0] cuenta_1;
`endif

    demux_1a2_reg #(.ANCHO(ANCHO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vaciar   (vaciar),
        .bus      (bus.slave)
`ifdef DEMUX_1A2_CONTADORES_EN
        ,
        .cuenta_0 (cuenta_0),
        .cuenta_1 (cuenta_1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vaciar = 1'b0;
        bus.entrada_valida = 1'b1; bus.sel = 1'b0; bus.entrada = 11'h7FF;
        bus.salida_0_lista = 1'b0; bus.salida_1_lista = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.salida_0_valida, bus.salida_1_valida} !== 2'b00) begin
                errors++; $display("FAIL reset_valids got %b required 00", {bus.salida_0_valida, bus.salida_1_valida});
            end
            checks++;
            if (bus.salida_0 !== 11'h000 || bus.salida_1 !== 11'h000) begin
                errors++; $display("FAIL reset_salidas got %h/%h required 000/000", bus.salida_0, bus.salida_1);
            end
        end
        bus.entrada_valida = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.salida_0_valida, bus.salida_1_valida, bus.entrada_lista} !== 3'b001) begin
                errors++; $display("FAIL idle_after_reset got v0v1lista=%b required 001", {bus.salida_0_valida, bus.salida_1_valida, bus.entrada_lista});
            end
        end
    endtask

    task automatic test_routing();
        bus.salida_0_lista = 1'b1; bus.salida_1_lista = 1'b1;
        bus.entrada_valida = 1'b1; bus.sel = 1'b0; bus.entrada = 11'h123;
        tick();
        checks++;
        if (bus.salida_0_valida !== 1'b1 || bus.salida_0 !== 11'h123 || bus.salida_1_valida !== 1'b0) begin
            errors++; $display("FAIL route_ch0 got v0=%b s0=%h v1=%b required 1 123 0", bus.salida_0_valida, bus.salida_0, bus.salida_1_valida);
        end
        bus.sel = 1'b1; bus.entrada = 11'h456;
        tick();
        checks++;
        if (bus.salida_0_valida !== 1'b0 || bus.salida_1_valida !== 1'b1 || bus.salida_1 !== 11'h456) begin
            errors++; $display("FAIL route_ch1 got v0=%b v1=%b s1=%h required 0 1 456", bus.salida_0_valida, bus.salida_1_valida, bus.salida_1);
        end
        bus.entrada_valida = 1'b0;
        tick();
        checks++;
        if ({bus.salida_0_valida, bus.salida_1_valida} !== 2'b00) begin
            errors++; $display("FAIL route_drain got %b required 00", {bus.salida_0_valida, bus.salida_1_valida});
        end
    endtask

    task automatic test_backpressure();
        bus.salida_0_lista = 1'b0; bus.salida_1_lista = 1'b0;
        bus.entrada_valida = 1'b1; bus.sel = 1'b0; bus.entrada = 11'h001;
        tick();
        bus.entrada = 11'h002; #1;
        checks++;
        if (bus.entrada_lista !== 1'b1) begin
            errors++; $display("FAIL bp_lista_count1 got %b required 1", bus.entrada_lista);
        end
        tick();
        bus.entrada = 11'h003; #1;
        checks++;
        if (bus.entrada_lista !== 1'b0) begin
            errors++; $display("FAIL bp_lista_full got %b required 0", bus.entrada_lista);
        end
        tick();
        checks++;
        if (bus.salida_0_valida !== 1'b1 || bus.salida_0 !== 11'h001) begin
            errors++; $display("FAIL bp_head_held got v0=%b s0=%h required 1 001", bus.salida_0_valida, bus.salida_0);
        end
        bus.sel = 1'b1; bus.entrada = 11'h004; #1;
        checks++;
        if (bus.entrada_lista !== 1'b1) begin
            errors++; $display("FAIL bp_other_lista got %b required 1", bus.entrada_lista);
        end
        tick();
        checks++;
        if (bus.salida_1_valida !== 1'b1 || bus.salida_1 !== 11'h004) begin
            errors++; $display("FAIL bp_other_ch got v1=%b s1=%h required 1 004", bus.salida_1_valida, bus.salida_1);
        end
        // 0x003 is re-presented; consumer 0 now ready
        bus.sel = 1'b0; bus.entrada = 11'h003; bus.salida_0_lista = 1'b1; #1;
        checks++;
        if (bus.entrada_lista !== 1'b0 || bus.salida_0 !== 11'h001) begin
            errors++; $display("FAIL bp_no_passthru got lista=%b s0=%h required 0 001", bus.entrada_lista, bus.salida_0);
        end
        tick();
        checks++;
        if (bus.salida_0 !== 11'h002 || bus.entrada_lista !== 1'b1) begin
            errors++; $display("FAIL bp_pop2 got s0=%h lista=%b required 002 1", bus.salida_0, bus.entrada_lista);
        end
        tick();
        checks++;
        if (bus.salida_0_valida !== 1'b1 || bus.salida_0 !== 11'h003) begin
            errors++; $display("FAIL bp_pop3 got v0=%b s0=%h required 1 003", bus.salida_0_valida, bus.salida_0);
        end
        bus.entrada_valida = 1'b0;
        tick();
        checks++;
        if (bus.salida_0_valida !== 1'b0) begin
            errors++; $display("FAIL bp_empty0 got %b required 0", bus.salida_0_valida);
        end
        bus.salida_1_lista = 1'b1;
        tick();
        checks++;
        if (bus.salida_1_valida !== 1'b0) begin
            errors++; $display("FAIL bp_empty1 got %b required 0", bus.salida_1_valida);
        end
    endtask

    task automatic test_push_pop();
        bus.salida_0_lista = 1'b0; bus.salida_1_lista = 1'b0;
        bus.entrada_valida = 1'b1; bus.sel = 1'b0; bus.entrada = 11'h0AA;
        tick();
        bus.salida_0_lista = 1'b1; bus.entrada = 11'h0BB; #1;
        checks++;
        if (bus.salida_0 !== 11'h0AA || bus.entrada_lista !== 1'b1) begin
            errors++; $display("FAIL pp_before got s0=%h lista=%b required 0aa 1", bus.salida_0, bus.entrada_lista);
        end
        tick();
        checks++;
        if (bus.salida_0_valida !== 1'b1 || bus.salida_0 !== 11'h0BB) begin
            errors++; $display("FAIL pp_after got v0=%b s0=%h required 1 0bb", bus.salida_0_valida, bus.salida_0);
        end
        bus.entrada_valida = 1'b0;
        tick();
        checks++;
        if (bus.salida_0_valida !== 1'b0) begin
            errors++; $display("FAIL pp_count1 got v0=%b required 0", bus.salida_0_valida);
        end
    endtask

    task automatic test_flush();
        logic [11:0] plan [4];
        plan[0] = {1'b0, 11'h011}; plan[1] = {1'b0, 11'h022};
        plan[2] = {1'b1, 11'h033}; plan[3] = {1'b1, 11'h044};
        bus.salida_0_lista = 1'b0; bus.salida_1_lista = 1'b0;
        bus.entrada_valida = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sel = plan[i][11]; bus.entrada = plan[i][10:0];
            tick();
        end
        checks++;
        if ({bus.salida_0_valida, bus.salida_1_valida} !== 2'b11 || bus.salida_0 !== 11'h011 || bus.salida_1 !== 11'h033) begin
            errors++; $display("FAIL fl_filled got v=%b s0=%h s1=%h required 11 011 033", {bus.salida_0_valida, bus.salida_1_valida}, bus.salida_0, bus.salida_1);
        end
        vaciar = 1'b1; bus.sel = 1'b0; bus.entrada = 11'h3FF;
        tick();
        vaciar = 1'b0; bus.entrada_valida = 1'b0;
        checks++;
        if ({bus.salida_0_valida, bus.salida_1_valida, bus.entrada_lista} !== 3'b001) begin
            errors++; $display("FAIL fl_empty got v0v1lista=%b required 001", {bus.salida_0_valida, bus.salida_1_valida, bus.entrada_lista});
        end
        bus.salida_0_lista = 1'b1; bus.salida_1_lista = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.salida_0_valida, bus.salida_1_valida} !== 2'b00) begin
                errors++; $display("FAIL fl_stays_empty got %b required 00", {bus.salida_0_valida, bus.salida_1_valida});
            end
        end
        // Flush beats a push into a non-full channel
        vaciar = 1'b1; bus.entrada_valida = 1'b1; bus.sel = 1'b1; bus.entrada = 11'h3FF;
        tick();
        vaciar = 1'b0; bus.entrada_valida = 1'b0;
        checks++;
        if (bus.salida_1_valida !== 1'b0) begin
            errors++; $display("FAIL fl_wins_push got v1=%b required 0", bus.salida_1_valida);
        end
        bus.entrada_valida = 1'b1; bus.sel = 1'b0; bus.entrada = 11'h155;
        tick();
        bus.entrada_valida = 1'b0;
        checks++;
        if (bus.salida_0_valida !== 1'b1 || bus.salida_0 !== 11'h155) begin
            errors++; $display("FAIL fl_reuse got v0=%b s0=%h required 1 155", bus.salida_0_valida, bus.salida_0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.salida_0_lista = 1'b0; bus.salida_1_lista = 1'b0;
        bus.entrada_valida = 1'b1; bus.sel = 1'b0; bus.entrada = 11'h2A5;
        tick();
        bus.entrada = 11'h15A;
        tick();
        bus.entrada_valida = 1'b0;
        rst_n = 1'b0; #1;
        checks++;
        if (bus.salida_0_valida !== 1'b0 || bus.salida_0 !== 11'h000) begin
            errors++; $display("FAIL rst_async got v0=%b s0=%h required 0 000", bus.salida_0_valida, bus.salida_0);
        end
        tick();
        rst_n = 1'b1;
        bus.salida_0_lista = 1'b1;
        tick();
        checks++;
        if ({bus.salida_0_valida, bus.salida_1_valida} !== 2'b00) begin
            errors++; $display("FAIL rst_no_replay got %b required 00", {bus.salida_0_valida, bus.salida_1_valida});
        end
    endtask

`ifdef DEMUX_1A2_CONTADORES_EN
    task automatic test_counters();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        checks++;
        if (cuenta_0 !== 16'h0000 || cuenta_1 !== 16'h0000) begin
            errors++; $display("FAIL cnt_reset got %h/%h required 0000/0000", cuenta_0, cuenta_1);
        end
        bus.salida_0_lista = 1'b0; bus.salida_1_lista = 1'b1;
        bus.entrada_valida = 1'b1; bus.sel = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.entrada = 11'(i);
            tick();
        end
        checks++;
        if (cuenta_1 !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_prewrap got %h required ffff", cuenta_1);
        end
        tick();
        checks++;
        if (cuenta_1 !== 16'h0000) begin
            errors++; $display("FAIL cnt_wrap got %h required 0000", cuenta_1);
        end
        bus.entrada_valida = 1'b0;
        tick();
        checks++;
        if (cuenta_1 !== 16'h0001 || cuenta_0 !== 16'h0000) begin
            errors++; $display("FAIL cnt_final got %h/%h required 0000/0001", cuenta_0, cuenta_1);
        end
        vaciar = 1'b1;
        tick();
        vaciar = 1'b0;
        checks++;
        if (cuenta_1 !== 16'h0001 || cuenta_0 !== 16'h0000) begin
            errors++; $display("FAIL cnt_flush got %h/%h required 0000/0001", cuenta_0, cuenta_1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_reset_mid();
`ifdef DEMUX_1A2_CONTADORES_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demux_1a2_reg
